// File: rtl/hcsr04_zone_filter_if.sv
// Bundles the measurement-side inputs and the filtered zone outputs of
// hcsr04_zone_filter. The master drives enable and the band bits; the slave
// (the filter) returns the filtered zone status.
//
// Signalling: zone is meaningful only while zone_valid is high. zone_change
// is a single-cycle event that accompanies each update of zone. It carries
// no back-pressure, so consumers must sample it on the cycle it is high.
// state_dbg mirrors the filter state register for observation only.
interface hcsr04_zone_filter_if;
  logic       enable;
  logic       level1;
  logic       level2;
  logic [1:0] zone;
  logic       zone_valid;
  logic       zone_change;
  logic       alarm;
  logic [7:0] change_count;
  logic [1:0] state_dbg;

  modport master (
    output enable, level1, level2,
    input  zone, zone_valid, zone_change, alarm, change_count, state_dbg
  );

  modport slave (
    input  enable, level1, level2,
    output zone, zone_valid, zone_change, alarm, change_count, state_dbg
  );
endinterface

// File: rtl/hcsr04_zone_filter.sv
// Debounces the two-bit band code from the ultrasonic stage into a stable
// zone (NEAR=01, FAR=10, OFF=11). The code is examined once per sample
// strobe. A new zone is accepted only after CONFIRM matching strobes. A
// persistent NEAR raises alarm after ALARM_SAMPLES locked strobes.
module hcsr04_zone_filter #(
  parameter logic [19:0] SAMPLE_DIV    = 20'd500000,
  parameter logic [2:0]  CONFIRM       = 3'd4,
  parameter logic [7:0]  ALARM_SAMPLES = 8'd50
) (
  input logic               clk,
  input logic               rst,
  hcsr04_zone_filter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  code_q;
  logic [19:0] cnt, cnt_n;
  logic [1:0]  cand, cand_n;
  logic [2:0]  match, match_n;
  logic [1:0]  zone, zone_n;
  logic        pulse, pulse_n;
  logic [7:0]  acnt, acnt_n;
  logic [7:0]  chg_cnt, chg_cnt_n;
  logic        strobe;
  logic        qualify;
  logic [2:0]  match_inc;

  // The strobe marks the last count of each sample period.
  assign strobe    = (cnt == SAMPLE_DIV - 20'd1);
  // Only NEAR and FAR codes advance acquisition; 00 is ignored outright.
  assign qualify   = strobe && ((code_q == 2'b01) || (code_q == 2'b10));
  assign match_inc = match + 3'd1;

  // Next-state and datapath decisions; a dropped enable (or an OFF code
  // on a strobe) overrides everything except reset.
  always_comb begin
    state_n   = state;
    cnt_n     = strobe ? 20'd0 : cnt + 20'd1;
    cand_n    = cand;
    match_n   = match;
    zone_n    = zone;
    pulse_n   = 1'b0;
    acnt_n    = acnt;
    chg_cnt_n = chg_cnt;

    if (!bus.enable || (strobe && (code_q == 2'b11))) begin
      state_n = ST_PAUSED;
      cnt_n   = 20'd0;
      cand_n  = 2'b11;
      match_n = 3'd0;
      zone_n  = 2'b11;
      acnt_n  = 8'd0;
    end else begin
      case (state)
        ST_PAUSED: begin
          if (qualify) begin
            state_n = ST_ACQUIRE;
            cand_n  = code_q;
            match_n = 3'd1;
          end
        end
        ST_ACQUIRE: begin
          if (qualify) begin
            if (code_q == cand) begin
              match_n = match_inc;
            end else begin
              cand_n  = code_q;
              match_n = 3'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (qualify) begin
            if (code_q == zone) begin
              match_n = 3'd0;
            end else if (code_q == cand) begin
              match_n = match_inc;
            end else begin
              cand_n  = code_q;
              match_n = 3'd1;
            end
          end
          if (strobe && (zone == 2'b01) && (acnt != ALARM_SAMPLES)) begin
            acnt_n = acnt + 8'd1;
          end
        end
        default: begin
          state_n = ST_PAUSED;
        end
      endcase

      // Confirmation reached: commit the candidate as the new zone.
      if (qualify && (match_n == CONFIRM)) begin
        state_n = ST_LOCKED;
        zone_n  = cand_n;
        match_n = 3'd0;
        pulse_n = 1'b1;
        acnt_n  = 8'd0;
        if (chg_cnt != 8'hff) begin
          chg_cnt_n = chg_cnt + 8'd1;
        end
      end

      // The alarm counter only lives while locked on NEAR.
      if ((state_n != ST_LOCKED) || (zone_n != 2'b01)) begin
        acnt_n = 8'd0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_PAUSED;
      code_q  <= 2'b00;
      cnt     <= 20'd0;
      cand    <= 2'b11;
      match   <= 3'd0;
      zone    <= 2'b11;
      pulse   <= 1'b0;
      acnt    <= 8'd0;
      chg_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      code_q  <= {bus.level1, bus.level2};
      cnt     <= cnt_n;
      cand    <= cand_n;
      match   <= match_n;
      zone    <= zone_n;
      pulse   <= pulse_n;
      acnt    <= acnt_n;
      chg_cnt <= chg_cnt_n;
    end
  end

  assign bus.zone         = zone;
  assign bus.zone_valid   = (state == ST_LOCKED);
  assign bus.zone_change  = pulse;
  assign bus.alarm        = (state == ST_LOCKED) && (zone == 2'b01) &&
                            (acnt == ALARM_SAMPLES);
  assign bus.change_count = chg_cnt;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_hcsr04_zone_filter.sv
// Bench for hcsr04_zone_filter with a short sample period.
module tb_hcsr04_zone_filter;

  localparam int SAMPLE_DIV    = 4;
  localparam int CONFIRM       = 3;
  localparam int ALARM_SAMPLES = 5;

  logic clk;
  logic rst;
  hcsr04_zone_filter_if bus();

  hcsr04_zone_filter #(
    .SAMPLE_DIV    (20'(SAMPLE_DIV)),
    .CONFIRM       (3'(CONFIRM)),
    .ALARM_SAMPLES (8'(ALARM_SAMPLES))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {zone_change, zone[1:0], zone_valid, alarm, change_count[7:0]}
  logic [12:0] exp_q[$];

  // ---------------- reference model ----------------
  // Tracks what the filter must present after each clock edge: whether it
  // is paused, acquiring or locked, the candidate and its match tally, the
  // sample-period position and the one-register delay on the band code.
  bit         m_active;
  bit         m_locked;
  logic [1:0] m_zone;
  logic [1:0] m_cand;
  int         m_match;
  int         m_acnt;
  int         m_cnt;
  int         m_changes;
  logic [1:0] m_code;
  bit         m_pulse;

  task automatic model_edge(input bit r, input bit en, input logic [1:0] lv);
    bit         strobe;
    bit         qual;
    bit         was_locked;
    logic [1:0] c;
    strobe     = (m_cnt == SAMPLE_DIV - 1);
    c          = m_code;
    m_code     = r ? 2'b00 : lv;
    m_pulse    = 1'b0;
    was_locked = m_locked;
    if (r) begin
      m_active = 0; m_locked = 0; m_zone = 2'b11; m_cand = 2'b11;
      m_match = 0; m_acnt = 0; m_cnt = 0; m_changes = 0;
      return;
    end
    if (!en || (strobe && c == 2'b11)) begin
      m_active = 0; m_locked = 0; m_zone = 2'b11;
      m_match = 0; m_acnt = 0; m_cnt = 0;
      return;
    end
    m_cnt = strobe ? 0 : m_cnt + 1;
    qual  = strobe && (c == 2'b01 || c == 2'b10);
    if (qual) begin
      if (!m_active) begin
        m_active = 1; m_cand = c; m_match = 1;
      end else if (m_locked && c == m_zone) begin
        m_match = 0;
      end else if (c == m_cand) begin
        m_match = m_match + 1;
      end else begin
        m_cand = c; m_match = 1;
      end
      if (m_match == CONFIRM) begin
        m_locked = 1; m_zone = m_cand; m_match = 0; m_pulse = 1;
        if (m_changes < 255) m_changes = m_changes + 1;
      end
    end
    if (!m_locked || m_zone != 2'b01) m_acnt = 0;
    else if (strobe && was_locked && !m_pulse && m_acnt < ALARM_SAMPLES) m_acnt = m_acnt + 1;
  endtask

  function automatic logic [12:0] model_out();
    logic alarm_exp;
    alarm_exp = m_locked && (m_zone == 2'b01) && (m_acnt == ALARM_SAMPLES);
    return {m_pulse, m_zone, m_locked, alarm_exp, 8'(m_changes)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit en, input logic [1:0] lv);
    @(negedge clk);
    rst        = r;
    bus.enable = en;
    bus.level1 = lv[1];
    bus.level2 = lv[0];
    model_edge(r, en, lv);
    exp_q.push_back(model_out());
  endtask

  task automatic period(input bit en, input logic [1:0] lv);
    repeat (SAMPLE_DIV) drive(1'b0, en, lv);
  endtask

  // Wait for the edge that consumes the last driven inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [12:0] e;
    logic [12:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {bus.zone_change, bus.zone, bus.zone_valid, bus.alarm, bus.change_count};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t got chg=%b zone=%b valid=%b alarm=%b count=%0d expected chg=%b zone=%b valid=%b alarm=%b count=%0d",
                   $time, got[12], got[11:10], got[9], got[8], got[7:0],
                   e[12], e[11:10], e[9], e[8], e[7:0]);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] seq37 [6];
  logic [1:0] seq40 [5];

  initial begin
    logic [1:0] lv;
    bit         en;
    bit         r;
    int         k;

    rst = 1'b1; bus.enable = 1'b0; bus.level1 = 1'b0; bus.level2 = 1'b0;
    seq37[0] = 2'b10; seq37[1] = 2'b10; seq37[2] = 2'b01;
    seq37[3] = 2'b10; seq37[4] = 2'b10; seq37[5] = 2'b10;
    seq40[0] = 2'b01; seq40[1] = 2'b00; seq40[2] = 2'b01;
    seq40[3] = 2'b00; seq40[4] = 2'b01;

    fork
      monitor_loop();
    join_none

    // Reset for two cycles.
    drive(1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 2'b00);
    settle();
    check("reset_zone", 16'(bus.zone), 16'h3);
    check("reset_valid", 16'(bus.zone_valid), 16'h0);
    check("reset_count", 16'(bus.change_count), 16'h0);

    // NEAR held: lock on the third strobe.
    period(1'b1, 2'b01);
    period(1'b1, 2'b01);
    settle();
    check("acq_not_yet_valid", 16'(bus.zone_valid), 16'h0);
    period(1'b1, 2'b01);
    settle();
    check("lock_pulse", 16'(bus.zone_change), 16'h1);
    check("lock_zone", 16'(bus.zone), 16'h1);
    check("lock_count", 16'(bus.change_count), 16'h1);

    // Alarm after five locked NEAR strobes, then a move to FAR clears it.
    repeat (4) period(1'b1, 2'b01);
    settle();
    check("alarm_before_5", 16'(bus.alarm), 16'h0);
    period(1'b1, 2'b01);
    settle();
    check("alarm_at_5", 16'(bus.alarm), 16'h1);
    repeat (3) period(1'b1, 2'b10);
    settle();
    check("far_zone", 16'(bus.zone), 16'h2);
    check("far_alarm_clear", 16'(bus.alarm), 16'h0);
    check("far_count", 16'(bus.change_count), 16'h2);

    // One-cycle enable drop mid-period.
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 2'b10);
    settle();
    check("pause_zone", 16'(bus.zone), 16'h3);
    check("pause_valid", 16'(bus.zone_valid), 16'h0);
    check("pause_no_pulse", 16'(bus.zone_change), 16'h0);
    check("pause_count_kept", 16'(bus.change_count), 16'h2);
    period(1'b1, 2'b01);
    period(1'b1, 2'b01);
    settle();
    check("relock_not_yet", 16'(bus.zone_valid), 16'h0);
    period(1'b1, 2'b01);
    settle();
    check("relock_zone", 16'(bus.zone), 16'h1);

    // Interrupted challenger sequence.
    for (int i = 0; i < 6; i++) begin
      period(1'b1, seq37[i]);
      settle();
      check("seq37_zone", 16'(bus.zone), (i < 5) ? 16'h1 : 16'h2);
    end
    check("seq37_count", 16'(bus.change_count), 16'h4);

    // Code 00 interleaved is ignored.
    drive(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      period(1'b1, seq40[i]);
      settle();
      check("seq40_valid", 16'(bus.zone_valid), (i < 4) ? 16'h0 : 16'h1);
    end
    check("seq40_zone", 16'(bus.zone), 16'h1);

    // Drive change_count into saturation.
    for (int i = 0; i < 260; i++) begin
      lv = (i % 2 == 0) ? 2'b10 : 2'b01;
      repeat (CONFIRM) period(1'b1, lv);
    end
    settle();
    check("count_saturated", 16'(bus.change_count), 16'hff);

    // Reset in the middle of acquisition.
    drive(1'b0, 1'b0, 2'b00);
    period(1'b1, 2'b01);
    period(1'b1, 2'b01);
    drive(1'b1, 1'b1, 2'b01);
    settle();
    check("midacq_rst_zone", 16'(bus.zone), 16'h3);
    check("midacq_rst_valid", 16'(bus.zone_valid), 16'h0);
    check("midacq_rst_count", 16'(bus.change_count), 16'h0);
    check("midacq_rst_alarm", 16'(bus.alarm), 16'h0);
    repeat (3) period(1'b1, 2'b01);
    settle();
    check("post_rst_lock", 16'(bus.zone_change), 16'h1);

    // Randomised traffic against the model.
    lv = 2'b01;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        k = $urandom_range(0, 9);
        if (k == 0)      lv = 2'b00;
        else if (k == 1) lv = 2'b11;
        else             lv = (k % 2 == 0) ? 2'b01 : 2'b10;
      end
      en = ($urandom_range(0, 59) != 0);
      r  = ($urandom_range(0, 499) == 0);
      drive(r, en, lv);
    end

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
